// File: rtl/decode_stage_pkg.sv
// Shared CPU defines: opcodes, instruction field ranges and field helpers.
package decode_stage_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SLT  = 4'b0011;
  localparam logic [3:0] OP_AND  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_ADDI = 4'b0110;
  localparam logic [3:0] OP_JUMP = 4'b0111;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 8;
  localparam int RT_HI  = 7;
  localparam int RT_LO  = 4;
  localparam int RD_HI  = 3;
  localparam int RD_LO  = 0;
  localparam int IMM_HI = 3;
  localparam int IMM_LO = 0;
  localparam int JT_HI  = 11;

  typedef enum logic {ST_RUN, ST_FLUSH} dec_state_t;

  function automatic logic [3:0] get_op(input logic [15:0] ir);
    return ir[OP_HI:OP_LO];
  endfunction

  function automatic logic [3:0] get_rs(input logic [15:0] ir);
    return ir[RS_HI:RS_LO];
  endfunction

  function automatic logic [3:0] get_rt(input logic [15:0] ir);
    return ir[RT_HI:RT_LO];
  endfunction

  function automatic logic [3:0] get_rd(input logic [15:0] ir);
    return ir[RD_HI:RD_LO];
  endfunction

  function automatic logic [15:0] get_imm(input logic [15:0] ir);
    return {{12{ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]};
  endfunction

  // Jumps stay inside the current 4K page of the jump's own PC.
  function automatic logic [15:0] get_jtarget(input logic [15:0] ir, input logic [15:0] pc);
    return {pc[15:12], ir[JT_HI:0]};
  endfunction

endpackage

// File: rtl/regfile16.sv
// 16x16 register file: two combinational read ports, one write port,
// write-first bypass, R0 hardwired to zero.
module regfile16 (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  ra1,
  input  logic [3:0]  ra2,
  input  logic        wen,
  input  logic [3:0]  waddr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata1,
  output logic [15:0] rdata2
);

  logic [15:0] mem [16];

  // Storage; R0 is cleared by reset and never written, so it always reads 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (wen && (waddr != 4'd0)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports with same-cycle writeback bypass so a waiting consumer can issue now.
  always_comb begin
    rdata1 = mem[ra1];
    rdata2 = mem[ra2];
    if (wen && (waddr == ra1) && (ra1 != 4'd0)) rdata1 = wdata;
    if (wen && (waddr == ra2) && (ra2 != 4'd0)) rdata2 = wdata;
  end

endmodule

// File: rtl/decode_stage.sv
// Register-read / decode stage: operand fetch, ADDI and JUMP precompute,
// pending-write scoreboard for RAW stalls, and jump redirect with one flush slot.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | normal issue; STALL may hold fetch on a RAW hazard
// ST_FLUSH | squash the single wrong-path instruction behind a JUMP
module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] IRIN,
  input  logic [15:0] PCIN,
  input  logic        VALIDIN,
  input  logic        WEN,
  input  logic [3:0]  WADDR,
  input  logic [15:0] WDATA,
  output logic        STALL,
  output logic        JUMPEN,
  output logic [15:0] JUMPADDR,
  output logic        VALIDOUT,
  output logic [15:0] IROUT,
  output logic [15:0] PCOUT,
  output logic [15:0] DATAOUT1,
  output logic [15:0] DATAOUT2,
  output logic [15:0] DATAOUT3
);

  dec_state_t  state;
  logic [15:0] pend;
  logic [15:0] pend_set;
  logic [15:0] rdata1;
  logic [15:0] rdata2;
  logic [3:0]  op;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [3:0]  dst;
  logic        is_rtype;
  logic        is_addi;
  logic        is_jump;
  logic        hazard_rs;
  logic        hazard_rt;
  logic        issue;

  assign op       = get_op(IRIN);
  assign rs       = get_rs(IRIN);
  assign rt       = get_rt(IRIN);
  assign is_rtype = (op >= OP_ADD) && (op <= OP_OR);
  assign is_addi  = (op == OP_ADDI);
  assign is_jump  = (op == OP_JUMP);
  assign dst      = is_addi ? rt : get_rd(IRIN);

  regfile16 u_regfile (
    .CLK    (CLK),
    .RST    (RST),
    .ra1    (rs),
    .ra2    (rt),
    .wen    (WEN),
    .waddr  (WADDR),
    .wdata  (WDATA),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // A source being written back this cycle is bypassed, so it is not a hazard.
  assign hazard_rs = (is_rtype || is_addi) && pend[rs] && !(WEN && (WADDR == rs));
  assign hazard_rt = is_rtype && pend[rt] && !(WEN && (WADDR == rt));
  assign STALL     = VALIDIN && (state == ST_RUN) && (hazard_rs || hazard_rt);
  assign issue     = VALIDIN && (state == ST_RUN) && !STALL;

  // Mask of the destination claimed by the instruction issuing this cycle.
  always_comb begin
    pend_set = '0;
    if (issue && (is_rtype || is_addi) && (dst != 4'd0)) pend_set[dst] = 1'b1;
  end

  // Scoreboard: writeback clears, issue sets; set wins on the same bit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pend <= '0;
    end else begin
      pend <= (pend & ~(WEN ? (16'd1 << WADDR) : 16'd0)) | pend_set;
    end
  end

  // Issue FSM with registered ALU-stage outputs; anything not issued is a bubble.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= ST_RUN;
      JUMPEN   <= 1'b0;
      JUMPADDR <= '0;
      VALIDOUT <= 1'b0;
      IROUT    <= '0;
      PCOUT    <= '0;
      DATAOUT1 <= '0;
      DATAOUT2 <= '0;
      DATAOUT3 <= '0;
    end else begin
      JUMPEN   <= 1'b0;
      VALIDOUT <= 1'b0;
      IROUT    <= '0;
      PCOUT    <= '0;
      DATAOUT1 <= '0;
      DATAOUT2 <= '0;
      DATAOUT3 <= '0;
      case (state)
        ST_RUN: begin
          if (issue && (is_rtype || is_addi || is_jump)) begin
            VALIDOUT <= 1'b1;
            IROUT    <= IRIN;
            PCOUT    <= PCIN;
            if (is_rtype) begin
              DATAOUT2 <= rdata1;
              DATAOUT3 <= rdata2;
            end else if (is_addi) begin
              DATAOUT2 <= rdata1 + get_imm(IRIN);
            end else begin
              DATAOUT1 <= get_jtarget(IRIN, PCIN);
              JUMPEN   <= 1'b1;
              JUMPADDR <= get_jtarget(IRIN, PCIN);
              state    <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: state <= ST_RUN;
        default:  state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed test-plan steps followed by randomized traffic, all checked against
// an instruction-level reference model of the decode stage.
module tb_decode_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] IRIN;
  logic [15:0] PCIN;
  logic        VALIDIN;
  logic        WEN;
  logic [3:0]  WADDR;
  logic [15:0] WDATA;
  logic        STALL;
  logic        JUMPEN;
  logic [15:0] JUMPADDR;
  logic        VALIDOUT;
  logic [15:0] IROUT;
  logic [15:0] PCOUT;
  logic [15:0] DATAOUT1;
  logic [15:0] DATAOUT2;
  logic [15:0] DATAOUT3;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [15:0] m_rf [16];
  bit   [15:0] m_pend;
  bit          m_flush;
  bit          m_last_stall;

  always #5 CLK = ~CLK;

  decode_stage dut (
    .CLK(CLK), .RST(RST), .IRIN(IRIN), .PCIN(PCIN), .VALIDIN(VALIDIN),
    .WEN(WEN), .WADDR(WADDR), .WDATA(WDATA), .STALL(STALL), .JUMPEN(JUMPEN),
    .JUMPADDR(JUMPADDR), .VALIDOUT(VALIDOUT), .IROUT(IROUT), .PCOUT(PCOUT),
    .DATAOUT1(DATAOUT1), .DATAOUT2(DATAOUT2), .DATAOUT3(DATAOUT3)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_rf[i] = 16'h0000;
    m_pend       = '0;
    m_flush      = 1'b0;
    m_last_stall = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"},  {15'd0, STALL},    16'h0);
    chk({tag, "_valid"},  {15'd0, VALIDOUT}, 16'h0);
    chk({tag, "_jumpen"}, {15'd0, JUMPEN},   16'h0);
    chk({tag, "_jaddr"},  JUMPADDR,          16'h0);
    chk({tag, "_ir"},     IROUT,             16'h0);
    chk({tag, "_pc"},     PCOUT,             16'h0);
    chk({tag, "_d1"},     DATAOUT1,          16'h0);
    chk({tag, "_d2"},     DATAOUT2,          16'h0);
    chk({tag, "_d3"},     DATAOUT3,          16'h0);
  endtask

  // Register value an instruction sees this cycle (writeback bypass included).
  function automatic logic [15:0] m_read(input int r);
    if (r == 0) return 16'h0000;
    if (WEN && (int'(WADDR) == r)) return WDATA;
    return m_rf[r];
  endfunction

  // One clock of the model: called at posedge+1 with inputs already driven.
  task automatic run_cycle();
    int op, rs, rt, rd, dst;
    bit stall_m, issue, writes;
    logic [15:0] e_ir, e_pc, e_d1, e_d2, e_d3, e_jaddr;
    bit e_v, e_je;
    op = int'(IRIN[15:12]); rs = int'(IRIN[11:8]); rt = int'(IRIN[7:4]); rd = int'(IRIN[3:0]);
    stall_m = 1'b0;
    if (VALIDIN && !m_flush) begin
      if (op >= 1 && op <= 6 && m_pend[rs] && !(WEN && int'(WADDR) == rs)) stall_m = 1'b1;
      if (op >= 1 && op <= 5 && m_pend[rt] && !(WEN && int'(WADDR) == rt)) stall_m = 1'b1;
    end
    #1;
    chk("stall", {15'd0, STALL}, {15'd0, stall_m});
    issue = VALIDIN && !m_flush && !stall_m;
    e_v = 0; e_je = 0; e_ir = 0; e_pc = 0; e_d1 = 0; e_d2 = 0; e_d3 = 0; e_jaddr = 0;
    writes = 0; dst = 0;
    if (issue && op >= 1 && op <= 7) begin
      e_v = 1; e_ir = IRIN; e_pc = PCIN;
      if (op <= 5) begin
        e_d2 = m_read(rs); e_d3 = m_read(rt); writes = 1; dst = rd;
      end else if (op == 6) begin
        e_d2 = m_read(rs) + 16'(signed'(IRIN[3:0])); writes = 1; dst = rt;
      end else begin
        e_d1 = {PCIN[15:12], IRIN[11:0]}; e_je = 1; e_jaddr = e_d1;
      end
    end
    m_flush = issue && (op == 7);
    m_last_stall = stall_m;
    if (WEN) m_pend[WADDR] = 1'b0;
    if (writes && dst != 0) m_pend[dst] = 1'b1;
    if (WEN && WADDR != 4'd0) m_rf[WADDR] = WDATA;
    @(posedge CLK);
    #1;
    chk("validout", {15'd0, VALIDOUT}, {15'd0, e_v});
    chk("jumpen",   {15'd0, JUMPEN},   {15'd0, e_je});
    chk("irout",    IROUT,    e_ir);
    chk("pcout",    PCOUT,    e_pc);
    chk("dataout1", DATAOUT1, e_d1);
    chk("dataout2", DATAOUT2, e_d2);
    chk("dataout3", DATAOUT3, e_d3);
    if (e_je) chk("jumpaddr", JUMPADDR, e_jaddr);
  endtask

  task automatic drive(input bit v, input logic [15:0] ir, input logic [15:0] pc,
                       input bit wen, input logic [3:0] wa, input logic [15:0] wd);
    VALIDIN = v; IRIN = ir; PCIN = pc; WEN = wen; WADDR = wa; WDATA = wd;
    run_cycle();
  endtask

  initial begin
    logic [15:0] cur_ir, cur_pc;
    bit cur_v;
    RST = 1'b1; VALIDIN = 0; IRIN = 0; PCIN = 0; WEN = 0; WADDR = 0; WDATA = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk_all_zero("reset");
    RST = 1'b0;

    // register setup and first ADD
    drive(0, 16'h0000, 16'h0000, 1, 4'd3, 16'h0005);
    drive(0, 16'h0000, 16'h0000, 1, 4'd4, 16'h0003);
    drive(1, 16'h1345, 16'h0010, 0, 4'd0, 16'h0000);
    chk("add_ir", IROUT, 16'h1345);
    chk("add_d2", DATAOUT2, 16'h0005);
    chk("add_d3", DATAOUT3, 16'h0003);

    // ADDI with negative immediate, then the wrap case
    drive(1, 16'h632F, 16'h0011, 0, 4'd0, 16'h0000);
    chk("addi_d2", DATAOUT2, 16'h0004);
    drive(0, 16'h0000, 16'h0000, 1, 4'd3, 16'hFFFF);
    drive(1, 16'h6321, 16'h0012, 0, 4'd0, 16'h0000);
    chk("addi_wrap", DATAOUT2, 16'h0000);

    // SUB waits on R5 and issues in the writeback cycle with bypassed data
    drive(1, 16'h2516, 16'h0013, 0, 4'd0, 16'h0000);
    chk("sub_stall1", {15'd0, VALIDOUT}, 16'h0);
    drive(1, 16'h2516, 16'h0013, 0, 4'd0, 16'h0000);
    drive(1, 16'h2516, 16'h0013, 1, 4'd5, 16'h1234);
    chk("sub_bypass", DATAOUT2, 16'h1234);

    // JUMP and its flushed follower
    drive(1, 16'h7123, 16'h4000, 0, 4'd0, 16'h0000);
    chk("jump_addr", JUMPADDR, 16'h4123);
    chk("jump_d1", DATAOUT1, 16'h4123);
    drive(1, 16'h1111, 16'h4001, 0, 4'd0, 16'h0000);
    chk("flush_bubble", {15'd0, VALIDOUT}, 16'h0);
    drive(1, 16'h1111, 16'h4123, 0, 4'd0, 16'h0000);

    // illegal opcode and idle input
    drive(1, 16'hF000, 16'h4124, 0, 4'd0, 16'h0000);
    drive(0, 16'h1345, 16'h4125, 0, 4'd0, 16'h0000);

    // async reset in the middle of a stall
    drive(1, 16'h1345, 16'h4126, 0, 4'd0, 16'h0000);
    IRIN = 16'h2516; PCIN = 16'h4127; VALIDIN = 1;
    #1;
    chk("pre_rst_stall", {15'd0, STALL}, 16'h1);
    #2;
    RST = 1'b1;
    #1;
    model_reset();
    chk_all_zero("midrst");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    drive(1, 16'h2516, 16'h4127, 0, 4'd0, 16'h0000);
    chk("post_rst_issue", {15'd0, VALIDOUT}, 16'h1);

    // randomized traffic; fetch holds its instruction while stalled
    cur_ir = 16'h0000; cur_pc = 16'h0100; cur_v = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!m_last_stall) begin
        cur_v  = ($urandom_range(0, 3) != 0);
        cur_ir = 16'($urandom);
        if ($urandom_range(0, 3) != 0) cur_ir[15] = 1'b0;
        cur_pc = cur_pc + 16'd1;
      end
      drive(cur_v, cur_ir, cur_pc, ($urandom_range(0, 2) == 0),
            4'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
